btn_press_decoder: RTL
======================

// Module: btn_press_decoder
// PURPOSE
//   Downstream consumer of the button debouncer. Takes the clean, clk-synchronous
//   debounced button level and classifies each press as short, long or auto-repeat.
//   Drives an 8-bit LED count: a short press or a repeat adds 1, a long press clears it.
//   Replaces edge-clocked LED logic with fully synchronous single-clock pulses.
// PARAMETERS
//   LONG_CYC    100_000_000  hold cycles at which a press becomes long (1 s @ 100 MHz)
//   REPEAT_CYC   20_000_000  cycles between auto-repeat pulses while held long
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   btn_db     in   1  debounced button level, synchronous to clk, 1 = pressed
//   short_pls  out  1  one-cycle pulse: press released before LONG_CYC
//   long_pls   out  1  one-cycle pulse: press held for LONG_CYC cycles
//   rpt_pls    out  1  one-cycle pulse: auto-repeat tick during a long hold
//   held       out  1  1 while in PRESS or LONG state
//   LED        out  8  press counter
// BEHAVIOUR
//   - All outputs registered. Reset: short_pls/long_pls/rpt_pls/held = 0, LED = 0,
//     state = IDLE, hold_cnt = 0, rpt_cnt = 0, btn_q = 1.
//   - btn_q is btn_db delayed 1 cycle; rise = btn_db & ~btn_q.
//   - btn_q resets to 1: a button held through reset is ignored until released.
//   - Counter widths: hold_cnt $clog2(LONG_CYC), rpt_cnt $clog2(REPEAT_CYC), min 1.
//   - FSM states:
//     IDLE : on rise -> PRESS, hold_cnt <= 0. Otherwise stay.
//     PRESS: held = 1. If btn_db == 0 -> IDLE, short_pls = 1, LED <= LED + 1.
//            Else if hold_cnt == LONG_CYC-1 -> LONG, long_pls = 1, LED <= 0,
//            rpt_cnt <= 0. Else hold_cnt <= hold_cnt + 1.
//     LONG : held = 1. If btn_db == 0 -> IDLE, no pulse. Otherwise see CONFIGURATION.
//   - Latency: pulses are high in the cycle after the clk edge that samples the
//     qualifying btn_db value. Each pulse lasts exactly 1 cycle.
//   - Release and hold_cnt reaching terminal in the same cycle: release wins,
//     giving short_pls only.
//   - LED wraps: 8'hFF + 1 = 8'h00. There is no saturation.
//   - At most one of short_pls/long_pls/rpt_pls is high in any cycle.
//   - rst mid-press: immediate return to reset values. A still-held button must
//     be released and pressed again before it is counted.
//   - Unused state encoding -> IDLE.
// CONFIGURATION
//   BTN_AUTO_REPEAT_EN defined:
//     - In LONG, when rpt_cnt == REPEAT_CYC-1: rpt_pls = 1, LED <= LED + 1,
//       rpt_cnt <= 0. Otherwise rpt_cnt <= rpt_cnt + 1.
//     - The first repeat comes REPEAT_CYC cycles after long_pls.
//   BTN_AUTO_REPEAT_EN undefined:
//     - rpt_pls is tied to 0 and no rpt_cnt is built. LONG only waits for release.
// TESTING  (bench overrides LONG_CYC=16, REPEAT_CYC=4)
//   1. Hold btn_db=1 through rst, then deassert rst -> LED=0, no pulses until a
//      release followed by a new press.
//   2. Press 5 cycles, then release -> exactly one short_pls, LED 0->1,
//      held=1 for 5 cycles.
//   3. LED preloaded to 8'hFF by 255 short presses, then one more short press
//      -> LED=8'h00.
//   4. Hold 16 cycles -> long_pls once, LED=0. Release -> no short_pls.
//   5. With BTN_AUTO_REPEAT_EN defined, hold 30 cycles -> long_pls at cycle 16,
//      rpt_pls at cycles 20/24/28, LED=3. Without the macro -> LED=0, rpt_pls never 1.
//   6. Release on the cycle hold_cnt==15, then assert rst during a subsequent
//      press -> short_pls only for the first press, then all outputs 0 on the
//      cycle after rst.

Source files
------------

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: classifies debounced button presses as short, long or
// auto-repeat and maintains an 8-bit press counter.
//   clk        system clock
//   rst        synchronous reset, active-high
//   btn_db     debounced button level (clk-synchronous), 1 = pressed
//   short_pls  1-cycle pulse: press released before LONG_CYC hold cycles
//   long_pls   1-cycle pulse: press held for LONG_CYC cycles
//   rpt_pls    1-cycle pulse: auto-repeat tick while held long
//   held       1 while a press is being tracked (PRESS or LONG)
//   LED        press counter (+1 short/repeat, cleared on long)
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat during long hold).
module btn_press_decoder #(
   parameter int unsigned LONG_CYC   = 100_000_000,
   parameter int unsigned REPEAT_CYC = 20_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_db,
   output logic       short_pls,
   output logic       long_pls,
   output logic       rpt_pls,
   output logic       held,
   output logic [7:0] LED
);

   localparam int unsigned HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [HOLD_W-1:0] hold_cnt, hold_nx;
   logic              btn_q;
   logic [7:0]        led_nx;
   logic              short_nx, long_nx, held_nx;
   logic              rise;

   assign rise = btn_db & ~btn_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
   logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;
   logic             rpt_nx;
`else
   logic unused_rpt;
   assign unused_rpt = (REPEAT_CYC == 0);
   assign rpt_pls    = 1'b0;
`endif

   // State and output registers; btn_q resets to 1 so a button held through
   // reset must be released before it can produce a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         btn_q     <= 1'b1;
         LED       <= 8'h00;
         short_pls <= 1'b0;
         long_pls  <= 1'b0;
         held      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         rpt_cnt   <= '0;
         rpt_pls   <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         hold_cnt  <= hold_nx;
         btn_q     <= btn_db;
         LED       <= led_nx;
         short_pls <= short_nx;
         long_pls  <= long_nx;
         held      <= held_nx;
`ifdef BTN_AUTO_REPEAT_EN
         rpt_cnt   <= rpt_cnt_nx;
         rpt_pls   <= rpt_nx;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      led_nx   = LED;
      short_nx = 1'b0;
      long_nx  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_nx = rpt_cnt;
      rpt_nx     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rise) begin
               state_nx = PRESS;
               hold_nx  = '0;
            end
         end
         PRESS: begin
            // Release takes priority over reaching the long threshold.
            if (!btn_db) begin
               state_nx = IDLE;
               short_nx = 1'b1;
               led_nx   = LED + 8'd1;
            end else if (hold_cnt == HOLD_W'(LONG_CYC - 1)) begin
               state_nx = LONG;
               long_nx  = 1'b1;
               led_nx   = 8'h00;
`ifdef BTN_AUTO_REPEAT_EN
               rpt_cnt_nx = '0;
`endif
            end else begin
               hold_nx = hold_cnt + HOLD_W'(1);
            end
         end
         LONG: begin
            if (!btn_db) begin
               state_nx = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
            end else if (rpt_cnt == RPT_W'(REPEAT_CYC - 1)) begin
               rpt_nx     = 1'b1;
               led_nx     = LED + 8'd1;
               rpt_cnt_nx = '0;
            end else begin
               rpt_cnt_nx = rpt_cnt + RPT_W'(1);
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
      held_nx = (state_nx == PRESS) || (state_nx == LONG);
   end

endmodule
